// File: rtl/decoder_scan_n.sv
// Registered active-low one-hot decoder with a self-sequencing scan mode.
// Scan walks the low bit across all N lines, dwelling STEP_DIV cycles on each.
module decoder_scan_n #(
   parameter int unsigned SEL_W    = 2,
   parameter int unsigned STEP_DIV = 1,
   parameter int unsigned WRAP     = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 En_n,
   input  logic                 Mode,
   input  logic                 Start,
   input  logic [SEL_W-1:0]     Sel,
   output logic [2**SEL_W-1:0]  W,
   output logic [SEL_W-1:0]     Idx,
   output logic                 Busy,
   output logic                 Done
);

   localparam int unsigned N     = 2 ** SEL_W;
   localparam int unsigned CNT_W = 8;
   localparam logic [N-1:0]     ONE       = {{(N - 1){1'b0}}, 1'b1};
   localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(N - 1);
   localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(STEP_DIV - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [N-1:0]       w_q, w_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         w_q     <= '1;
         idx_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      w_d     = '1;
      idx_d   = idx_q;
      cnt_d   = '0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!En_n) begin
               if (!Mode) begin
                  w_d   = ~(ONE << Sel);
                  idx_d = Sel;
               end else if (Start) begin
                  state_d = SCAN;
                  w_d     = ~ONE;
                  idx_d   = '0;
               end
            end
         end
         SCAN: begin
            // Abort is checked first so it wins over completion on the last dwell cycle.
            if (En_n || !Mode) begin
               state_d = IDLE;
            end else if (cnt_q == DWELL_END) begin
               if (idx_q != IDX_LAST) begin
                  idx_d = idx_q + 1'b1;
                  w_d   = ~(ONE << (idx_q + 1'b1));
               end else if (WRAP != 0) begin
                  idx_d = '0;
                  w_d   = ~ONE;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               w_d   = w_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign W    = w_q;
   assign Idx  = idx_q;
   assign Busy = (state_q == SCAN);
   assign Done = done_q;

endmodule
